// File: rtl/spi_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fgen_cmd_pkg
// Purpose  : Command word layout, opcodes and run-state encoding shared by
//            the SPI command decoder of the function generator.
// Revision : 1.0 - initial release
// ============================================================================
package fgen_cmd_pkg;

  // Opcodes carried in the top nibble of each 32-bit command word
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_RUN   = 4'h2;
  localparam logic [3:0] OP_STOP  = 4'h3;
  localparam logic [3:0] OP_CLEAR = 4'h4;

  // Field positions inside the command word
  localparam int OP_MSB   = 31;
  localparam int OP_W     = 4;
  localparam int ADDR_LSB = 14;

  // Run controller encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  // Extract the opcode nibble from a command word
  function automatic logic [OP_W-1:0] word_opcode(input logic [31:0] w);
    return w[OP_MSB -: OP_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Interface : spi_cmd_decoder_if
// Purpose   : Byte stream from the SPI receiver into the command decoder and
//             the decoded waveform-memory / run-control outputs.
// Revision  : 1.0 - initial release
// ============================================================================
interface spi_cmd_decoder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 14
);

  logic              ss_n;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [ADDR_W:0]   samples;
  logic              run_en;
  logic              cmd_err;
  logic [7:0]        tx_byte;

  // Byte source side (SPI receiver / testbench)
  modport master (
    output ss_n, rx_valid, rx_byte,
    input  mem_we, mem_addr, mem_din, samples, run_en, cmd_err, tx_byte
  );

  // Decoder side
  modport slave (
    input  ss_n, rx_valid, rx_byte,
    output mem_we, mem_addr, mem_din, samples, run_en, cmd_err, tx_byte
  );

endinterface
`default_nettype wire

// File: rtl/spi_cmd_decoder_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : spi_word_assembler
// Purpose  : Packs SS-framed SPI bytes (MSB first) into 32-bit words and
//            flags frames that end on a partial word.
// Revision : 1.0 - initial release
// ============================================================================
module spi_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        ss_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        word_vld,
  output logic [31:0] word,
  output logic        frame_err
);

  logic [1:0]  byte_cnt;
  logic [31:0] shreg;
  logic        take_byte;
  logic        unused_top;

  // A byte arriving while ss_n is high belongs to no frame and is dropped
  assign take_byte = rx_valid && !ss_n;

  // The 4th byte completes the word combinationally so the decoder can
  // register its outputs on the same edge
  assign word_vld  = take_byte && (byte_cnt == 2'd3);
  assign word      = {shreg[23:0], rx_byte};
  assign frame_err = ss_n && (byte_cnt != 2'd0);

  // Only the three most recent bytes feed the completed word
  assign unused_top = ^shreg[31:24];

  // Byte counter and shift register; ss_n high discards any partial word
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      shreg    <= 32'd0;
    end else if (ss_n) begin
      byte_cnt <= 2'd0;
    end else if (rx_valid) begin
      shreg    <= {shreg[23:0], rx_byte};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_decoder
// Purpose  : Decodes 32-bit SPI command words into waveform RAM writes and
//            a two-state run/stop controller for the function generator.
// Options  : SPI_CMD_STATUS_EN - drive a registered status byte on tx_byte
//            ({run_en, err_sticky, samples[5:0]}); otherwise tx_byte = 0.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_decoder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 14
) (
  input  logic              sysClk,
  input  logic              usrReset,
  spi_cmd_decoder_if.slave  bus
);

  import fgen_cmd_pkg::*;

  logic              word_vld;
  logic [31:0]       word;
  logic              frame_err;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W:0]   waddr_p1;
  logic              unused_word;

  run_state_t        state, state_nxt;
  logic              mem_we_reg,   mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_nxt;
  logic [DATA_W-1:0] mem_din_reg,  mem_din_nxt;
  logic [ADDR_W:0]   samples_reg,  samples_nxt;
  logic              cmd_err_reg,  cmd_err_nxt;

  spi_word_assembler u_word_asm (
    .clk       (sysClk),
    .rst       (usrReset),
    .ss_n      (bus.ss_n),
    .rx_valid  (bus.rx_valid),
    .rx_byte   (bus.rx_byte),
    .word_vld  (word_vld),
    .word      (word),
    .frame_err (frame_err)
  );

  assign opcode      = word_opcode(word);
  assign waddr       = word[ADDR_LSB +: ADDR_W];
  assign wdata       = word[DATA_W-1:0];
  // One bit wider than the address so the top address yields 2^ADDR_W
  assign waddr_p1    = {1'b0, waddr} + {{ADDR_W{1'b0}}, 1'b1};
  // Bits between the fields carry no meaning
  assign unused_word = ^word;

  // Run-state and decoded-output registers
  always_ff @(posedge sysClk) begin
    if (usrReset) begin
      state        <= ST_IDLE;
      mem_we_reg   <= 1'b0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
      samples_reg  <= '0;
      cmd_err_reg  <= 1'b0;
    end else begin
      state        <= state_nxt;
      mem_we_reg   <= mem_we_nxt;
      mem_addr_reg <= mem_addr_nxt;
      mem_din_reg  <= mem_din_nxt;
      samples_reg  <= samples_nxt;
      cmd_err_reg  <= cmd_err_nxt;
    end
  end

  // Opcode decode and run-controller transitions
  always_comb begin
    state_nxt    = state;
    mem_we_nxt   = 1'b0;
    mem_addr_nxt = mem_addr_reg;
    mem_din_nxt  = mem_din_reg;
    samples_nxt  = samples_reg;
    cmd_err_nxt  = frame_err;
    if (word_vld) begin
      case (opcode)
        OP_WRITE: begin
          // Rewriting the table while it is being played is refused
          if (state == ST_RUN) begin
            cmd_err_nxt = 1'b1;
          end else begin
            mem_we_nxt   = 1'b1;
            mem_addr_nxt = waddr;
            mem_din_nxt  = wdata;
            if (waddr_p1 > samples_reg) begin
              samples_nxt = waddr_p1;
            end
          end
        end
        OP_RUN: begin
          // Starting with an empty table is an error; RUN in RUN is a no-op
          if (state == ST_IDLE) begin
            if (samples_reg == '0) begin
              cmd_err_nxt = 1'b1;
            end else begin
              state_nxt = ST_RUN;
            end
          end
        end
        OP_STOP: begin
          state_nxt = ST_IDLE;
        end
        OP_CLEAR: begin
          state_nxt   = ST_IDLE;
          samples_nxt = '0;
        end
        default: begin
          cmd_err_nxt = 1'b1;
        end
      endcase
    end
  end

  assign bus.mem_we   = mem_we_reg;
  assign bus.mem_addr = mem_addr_reg;
  assign bus.mem_din  = mem_din_reg;
  assign bus.samples  = samples_reg;
  assign bus.run_en   = (state == ST_RUN);
  assign bus.cmd_err  = cmd_err_reg;

`ifdef SPI_CMD_STATUS_EN
  logic       err_sticky, err_sticky_nxt;
  logic       ss_n_prev;
  logic [7:0] tx_reg;

  // Sticky error: cleared by a new frame start, set by any error pulse
  always_comb begin
    err_sticky_nxt = err_sticky;
    if (ss_n_prev && !bus.ss_n) begin
      err_sticky_nxt = 1'b0;
    end
    if (cmd_err_nxt) begin
      err_sticky_nxt = 1'b1;
    end
  end

  // Status byte built from next-state values so it lines up with outputs
  always_ff @(posedge sysClk) begin
    if (usrReset) begin
      ss_n_prev  <= 1'b1;
      err_sticky <= 1'b0;
      tx_reg     <= 8'h00;
    end else begin
      ss_n_prev  <= bus.ss_n;
      err_sticky <= err_sticky_nxt;
      tx_reg     <= {(state_nxt == ST_RUN), err_sticky_nxt, samples_nxt[5:0]};
    end
  end

  assign bus.tx_byte = tx_reg;
`else
  assign bus.tx_byte = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cmd_decoder
// Purpose  : Directed self-checking bench for spi_cmd_decoder; expected
//            outputs are queued per command and compared after decode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_decoder;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 14;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [ADDR_W:0]   samples;
    logic              run;
    logic              err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  spi_cmd_decoder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spi_cmd_decoder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .sysClk   (clk),
    .usrReset (rst),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [7:0] a,
                                     input logic [13:0] d);
    return {op, 6'b0, a, d};
  endfunction

  task automatic push_exp(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] din, input logic [ADDR_W:0] samples,
                          input logic run, input logic err);
    exp_t e;
    e.we = we; e.addr = addr; e.din = din;
    e.samples = samples; e.run = run; e.err = err;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".mem_we"},   32'(bus.mem_we),   32'(e.we));
      chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(e.addr));
      chk({tag, ".mem_din"},  32'(bus.mem_din),  32'(e.din));
      chk({tag, ".samples"},  32'(bus.samples),  32'(e.samples));
      chk({tag, ".run_en"},   32'(bus.run_en),   32'(e.run));
      chk({tag, ".cmd_err"},  32'(bus.cmd_err),  32'(e.err));
    end
  endtask

  initial begin
    bus.ss_n     = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    rst          = 1'b1;
    repeat (3) tick();
    push_exp(1'b0, 8'h00, 14'h0000, 9'd0, 1'b0, 1'b0);
    check_out("reset");
    chk("reset.tx_byte", 32'(bus.tx_byte), 32'h00);
    rst      = 1'b0;
    bus.ss_n = 1'b0;
    tick();

    // First write, byte by byte
    push_exp(1'b1, 8'h01, 14'h0123, 9'd2, 1'b0, 1'b0);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h41); send_byte(8'h23);
    check_out("wr1");
    tick();
    chk("wr1.we_one_cycle", 32'(bus.mem_we), 32'd0);

    // Top address gives 2^ADDR_W samples; a lower address keeps the maximum
    push_exp(1'b1, 8'hFF, 14'h3FFF, 9'd256, 1'b0, 1'b0);
    send_word(mk(4'h1, 8'hFF, 14'h3FFF));
    check_out("wr_top");
    push_exp(1'b1, 8'h03, 14'h0055, 9'd256, 1'b0, 1'b0);
    send_word(mk(4'h1, 8'h03, 14'h0055));
    check_out("wr_keep_max");

    // Run, run again, write refused while running
    push_exp(1'b0, 8'h03, 14'h0055, 9'd256, 1'b1, 1'b0);
    send_word(32'h2000_0000);
    check_out("run");
`ifdef SPI_CMD_STATUS_EN
    chk("status.run_bit", 32'(bus.tx_byte[7]), 32'd1);
`endif
    push_exp(1'b0, 8'h03, 14'h0055, 9'd256, 1'b1, 1'b0);
    send_word(32'h2000_0000);
    check_out("run_in_run");
    push_exp(1'b0, 8'h03, 14'h0055, 9'd256, 1'b1, 1'b1);
    send_word(mk(4'h1, 8'h09, 14'h0007));
    check_out("wr_in_run");
    tick();
    chk("wr_in_run.err_one_cycle", 32'(bus.cmd_err), 32'd0);

    // Stop, stop again, clear, run on empty table
    push_exp(1'b0, 8'h03, 14'h0055, 9'd256, 1'b0, 1'b0);
    send_word(32'h3000_0000);
    check_out("stop");
`ifdef SPI_CMD_STATUS_EN
    chk("status.run_bit_clr", 32'(bus.tx_byte[7]), 32'd0);
`endif
    push_exp(1'b0, 8'h03, 14'h0055, 9'd256, 1'b0, 1'b0);
    send_word(32'h3000_0000);
    check_out("stop_in_idle");
    push_exp(1'b0, 8'h03, 14'h0055, 9'd0, 1'b0, 1'b0);
    send_word(32'h4000_0000);
    check_out("clear");
    push_exp(1'b0, 8'h03, 14'h0055, 9'd0, 1'b0, 1'b1);
    send_word(32'h2000_0000);
    check_out("run_empty");
`ifdef SPI_CMD_STATUS_EN
    chk("status.err_sticky", 32'(bus.tx_byte[6]), 32'd1);
`else
    chk("tx_byte_const", 32'(bus.tx_byte), 32'h00);
`endif

    // Frame break after two bytes, then a realigned write
    send_byte(8'h10); send_byte(8'h00);
    push_exp(1'b0, 8'h03, 14'h0055, 9'd0, 1'b0, 1'b1);
    bus.ss_n = 1'b1;
    tick();
    check_out("break");
    bus.ss_n = 1'b0;
    tick();
    chk("break.err_one_cycle", 32'(bus.cmd_err), 32'd0);
`ifdef SPI_CMD_STATUS_EN
    chk("status.sticky_clr", 32'(bus.tx_byte[6]), 32'd0);
`endif
    push_exp(1'b1, 8'h05, 14'h00AB, 9'd6, 1'b0, 1'b0);
    send_word(mk(4'h1, 8'h05, 14'h00AB));
    check_out("wr_after_break");

    // Unknown opcode
    push_exp(1'b0, 8'h05, 14'h00AB, 9'd6, 1'b0, 1'b1);
    send_word(mk(4'h7, 8'h12, 14'h0034));
    check_out("bad_opcode");

    // Fourth byte coinciding with ss_n high is a break, not a word
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h80);
    push_exp(1'b0, 8'h05, 14'h00AB, 9'd6, 1'b0, 1'b1);
    bus.ss_n     = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h11;
    tick();
    bus.rx_valid = 1'b0;
    check_out("drop_4th");
    bus.ss_n = 1'b0;
    tick();
    push_exp(1'b1, 8'h02, 14'h0011, 9'd6, 1'b0, 1'b0);
    send_word(mk(4'h1, 8'h02, 14'h0011));
    check_out("wr_realign");

    // Reset while running with three bytes buffered
    push_exp(1'b0, 8'h02, 14'h0011, 9'd6, 1'b1, 1'b0);
    send_word(32'h2000_0000);
    check_out("run2");
    send_byte(8'h10); send_byte(8'h08); send_byte(8'h00);
    rst = 1'b1;
    push_exp(1'b0, 8'h00, 14'h0000, 9'd0, 1'b0, 1'b0);
    tick();
    check_out("reset_mid");
    chk("reset_mid.tx_byte", 32'(bus.tx_byte), 32'h00);
    rst = 1'b0;
    push_exp(1'b1, 8'h10, 14'h0001, 9'd17, 1'b0, 1'b0);
    send_word(mk(4'h1, 8'h10, 14'h0001));
    check_out("wr_post_reset");

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Converts the byte stream from `spi_byte_if` into 32-bit command words and decodes them into waveform-memory writes and run/stop control for the function generator. It sits between `spi_byte_if` and the waveform block RAM / FIFO feeder, all in the `sysClk` (100 MHz) domain. It replaces ad-hoc byte counting with SS-framed word assembly, explicit opcode checking and a two-state run controller.

## Interface
- `ADDR_W`, default 8: waveform memory address width.
- `DATA_W`, default 14: DAC sample width.
- `sysClk` in 1: system clock, 100 MHz.
- `usrReset` in 1: synchronous, active-high reset.
- `ss_n` in 1: SPI slave select, active low, synchronous to `sysClk`.
- `rx_valid` in 1: one-cycle strobe, byte on `rx_byte` is valid.
- `rx_byte` in 8: received byte, MSB-first within the word.
- `mem_we` out 1: one-cycle waveform RAM write strobe.
- `mem_addr` out ADDR_W: write address.
- `mem_din` out DATA_W: write data.
- `samples` out ADDR_W+1: waveform length in samples, 0 to 2^ADDR_W.
- `run_en` out 1: level, function generator running.
- `cmd_err` out 1: one-cycle pulse on a rejected word or a broken frame.
- `tx_byte` out 8: status byte for MISO.

## Operation
- Word assembly: 2-bit byte counter. Each `rx_valid` shifts `rx_byte` into a 32-bit shift register. The 4th byte completes the word, raises internal `word_vld` for one cycle and returns the counter to 0.
- Frame break: `ss_n` high clears the counter. If the counter was non-zero, the partial word is discarded and `cmd_err` pulses.
- Word fields:
  - opcode = word[31:28]
  - addr = word[14+ADDR_W-1:14]
  - data = word[DATA_W-1:0]
  - all other bits are ignored.
- Opcodes:
  - 0x1 WRITE: `mem_we`=1, `mem_addr`=addr, `mem_din`=data. Then `samples` = max(`samples`, addr+1).
  - 0x2 RUN: `run_en`=1.
  - 0x3 STOP: `run_en`=0.
  - 0x4 CLEAR: `samples`=0, `run_en`=0.
  - Any other opcode: `cmd_err` pulse, no other effect.
- Run controller, state IDLE (`run_en`=0) or RUN (`run_en`=1):
  - IDLE→RUN on RUN with `samples`≠0. RUN with `samples`=0 gives `cmd_err` and stays in IDLE.
  - RUN→IDLE on STOP or CLEAR.
  - WRITE in RUN is rejected with `cmd_err`, no `mem_we`.
  - RUN in RUN and STOP in IDLE are no-ops without error.
- `samples` is ADDR_W+1 wide, so addr = 2^ADDR_W−1 gives exactly 2^ADDR_W with no wrap.

## Timing
- Reset values:
  - all outputs 0: `mem_we`, `mem_addr`, `mem_din`, `samples`, `run_en`, `cmd_err`, `tx_byte`
  - byte counter 0, shift register 0, state IDLE.
- Latency: every decoded output (`mem_we`, `mem_addr`, `mem_din`, `run_en` change, `cmd_err`) is registered and appears in the cycle after the 4th `rx_valid`.
- `samples` updates in the same cycle as `mem_we`.
- `mem_addr` and `mem_din` hold their values until the next accepted WRITE.
- `rx_valid` and `ss_n`=1 in the same cycle: `ss_n` wins and the byte is dropped. A counter of 3 plus this byte does not complete a word; it is a frame break with `cmd_err`.
- `usrReset` mid-word or mid-RUN: everything returns to reset values on the next edge, and the partial word is lost without `cmd_err`.
- Back-to-back words within one frame are legal with zero gap cycles. `rx_valid` spacing is at least 8 cycles by SPI rate, but the block must not depend on that.

## Configuration
- `SPI_CMD_STATUS_EN` defined: `tx_byte` = {`run_en`, `err_sticky`, `samples`[5:0]}, registered.
  - `err_sticky` sets on any `cmd_err`.
  - It clears on the falling edge of `ss_n`, i.e. a new frame start.
- Without the macro: `tx_byte` is constant 8'h00 and no `err_sticky` register exists.

## Structure
- Package `fgen_cmd_pkg` holds:
  - opcode constants `OP_WRITE`/`OP_RUN`/`OP_STOP`/`OP_CLEAR`
  - field bit positions (`OP_MSB`=31, `ADDR_LSB`=14)
  - run-state encoding `ST_IDLE`/`ST_RUN`.
- One sub-module: `spi_word_assembler`. It covers the byte counter, shift register, `ss_n` framing and the frame-error pulse. It outputs `word_vld` and `word` to the decoder in the parent.

## Test plan
- Reset, then bytes 0x10,0x00,0x41,0x23 → one cycle later:
  - `mem_we`=1, `mem_addr`=1, `mem_din`=0x0123, `samples`=2
  - `cmd_err`=0.
- WRITE to addr 0xFF, then RUN word 0x20000000 → `samples`=256, `run_en`=1 one cycle after the 4th byte.
  - A following WRITE gives `cmd_err` pulse and no `mem_we`.
- After CLEAR 0x40000000, send RUN → `cmd_err`=1 and `run_en` stays 0.
- Send 2 bytes, deassert `ss_n`, then a full WRITE to addr 5 → `cmd_err` pulse at the break, then a correct write to addr 5 (no misalignment).
- Opcode 0x7 → `cmd_err` pulse, all other outputs unchanged.
- Assert `usrReset` during RUN with 3 bytes buffered → all outputs 0 next cycle; a new full word decodes normally.
- With `SPI_CMD_STATUS_EN`:
  - after an error, `tx_byte`[6]=1
  - it clears on the next `ss_n` fall
  - `tx_byte`[7] tracks `run_en`.
